exec_stage_ctrl: RTL

- Execute-stage controller for the pipelined y86-64 core. Owns the E pipeline register that feeds execute_block (icode, ifun, valA, valB, valC) and the condition-code (CC) register.
- Decides when execute_block's flag outputs commit to CC, and evaluates branch/cmov conditions from committed CC.
- Applies stall/bubble control from the hazard unit and keeps saturating performance counters for executed instructions and jump mispredicts.

---
 rtl/exec_stage_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/exec_stage_ctrl.sv
// exec_stage_ctrl: execute-stage control for the pipelined y86-64 core.
// It owns the E pipeline register (icode, ifun, valA/B/C, dstE, dstM, stat)
// and the condition-code register. From the committed CC it evaluates
// branch/cmov conditions, and it keeps saturating counts of executed
// instructions and of jump mispredicts.
//
// Ports:
//   clk, rst               clock; synchronous active-high reset
//   E_stall, E_bubble      hazard-unit control of the E register
//   d_*                    decode-stage fields loaded into E
//   m_stat, W_stat         status of the downstream M and W instructions
//   alu_zf/sf/of           flags from execute_block for the E instruction
//   E_*                    registered E-stage fields
//   e_dstE, e_cnd, set_cc  combinational results for the current E instruction
//   cc                     committed {ZF,SF,OF}
//   cnt_exec, cnt_mispred  saturating performance counters
module exec_stage_ctrl #(
    parameter int unsigned CNT_W = 16,
    parameter logic [3:0]  RNONE = 4'hF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             E_stall,
    input  logic             E_bubble,
    input  logic [3:0]       d_icode,
    input  logic [3:0]       d_ifun,
    input  logic [63:0]      d_valA,
    input  logic [63:0]      d_valB,
    input  logic [63:0]      d_valC,
    input  logic [3:0]       d_dstE,
    input  logic [3:0]       d_dstM,
    input  logic [2:0]       d_stat,
    input  logic [2:0]       m_stat,
    input  logic [2:0]       W_stat,
    input  logic             alu_zf,
    input  logic             alu_sf,
    input  logic             alu_of,
    output logic [3:0]       E_icode,
    output logic [3:0]       E_ifun,
    output logic [63:0]      E_valA,
    output logic [63:0]      E_valB,
    output logic [63:0]      E_valC,
    output logic [3:0]       E_dstM,
    output logic [2:0]       E_stat,
    output logic [3:0]       e_dstE,
    output logic             e_cnd,
    output logic             set_cc,
    output logic [2:0]       cc,
    output logic [CNT_W-1:0] cnt_exec,
    output logic [CNT_W-1:0] cnt_mispred
);

    localparam logic [3:0] I_NOP   = 4'h1;
    localparam logic [3:0] I_RRMOV = 4'h2;
    localparam logic [3:0] I_OPQ   = 4'h6;
    localparam logic [3:0] I_JXX   = 4'h7;

    localparam logic [2:0] S_BUB = 3'd0;
    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [3:0]       icode_q, icode_d;
    logic [3:0]       ifun_q,  ifun_d;
    logic [63:0]      vala_q,  vala_d;
    logic [63:0]      valb_q,  valb_d;
    logic [63:0]      valc_q,  valc_d;
    logic [3:0]       dste_q,  dste_d;
    logic [3:0]       dstm_q,  dstm_d;
    logic [2:0]       stat_q,  stat_d;
    logic [2:0]       cc_q,    cc_d;
    logic [CNT_W-1:0] cnt_exec_q,    cnt_exec_d;
    logic [CNT_W-1:0] cnt_mispred_q, cnt_mispred_d;

    logic cond;
    logic set_cc_w;
    logic so;

    function automatic logic is_exc(input logic [2:0] s);
        return (s == S_HLT) || (s == S_ADR) || (s == S_INS);
    endfunction

    // Condition evaluation from committed CC only.
    always_comb begin
        cond = 1'b0;
        so   = cc_q[1] ^ cc_q[0];
        case (ifun_q)
            4'd0:    cond = 1'b1;
            4'd1:    cond = so | cc_q[2];
            4'd2:    cond = so;
            4'd3:    cond = cc_q[2];
            4'd4:    cond = ~cc_q[2];
            4'd5:    cond = ~so;
            4'd6:    cond = ~so & ~cc_q[2];
            default: cond = 1'b0;
        endcase
    end

    // An OPq may only commit flags when no older instruction has faulted.
    assign set_cc_w = (icode_q == I_OPQ) && !is_exc(m_stat) && !is_exc(W_stat);

    // Next-state for the E register, CC and counters.
    always_comb begin
        icode_d       = icode_q;
        ifun_d        = ifun_q;
        vala_d        = vala_q;
        valb_d        = valb_q;
        valc_d        = valc_q;
        dste_d        = dste_q;
        dstm_d        = dstm_q;
        stat_d        = stat_q;
        cc_d          = cc_q;
        cnt_exec_d    = cnt_exec_q;
        cnt_mispred_d = cnt_mispred_q;

        if (E_bubble) begin
            icode_d = I_NOP;
            ifun_d  = 4'h0;
            vala_d  = 64'h0;
            valb_d  = 64'h0;
            valc_d  = 64'h0;
            dste_d  = RNONE;
            dstm_d  = RNONE;
            stat_d  = S_BUB;
        end else if (!E_stall) begin
            icode_d = d_icode;
            ifun_d  = d_ifun;
            vala_d  = d_valA;
            valb_d  = d_valB;
            valc_d  = d_valC;
            dste_d  = d_dstE;
            dstm_d  = d_dstM;
            stat_d  = d_stat;
        end

        if (set_cc_w) begin
            cc_d = {alu_zf, alu_sf, alu_of};
        end

        // The E instruction leaves E on every unstalled edge.
        if (!E_stall) begin
            if ((stat_q != S_BUB) && (cnt_exec_q != CNT_MAX)) begin
                cnt_exec_d = cnt_exec_q + CNT_W'(1);
            end
            if ((icode_q == I_JXX) && (stat_q == S_AOK) && !e_cnd
                && (cnt_mispred_q != CNT_MAX)) begin
                cnt_mispred_d = cnt_mispred_q + CNT_W'(1);
            end
        end
    end

    // State registers; reset loads a bubble and the ZF-set CC.
    always_ff @(posedge clk) begin
        if (rst) begin
            icode_q       <= I_NOP;
            ifun_q        <= 4'h0;
            vala_q        <= 64'h0;
            valb_q        <= 64'h0;
            valc_q        <= 64'h0;
            dste_q        <= RNONE;
            dstm_q        <= RNONE;
            stat_q        <= S_BUB;
            cc_q          <= 3'b100;
            cnt_exec_q    <= '0;
            cnt_mispred_q <= '0;
        end else begin
            icode_q       <= icode_d;
            ifun_q        <= ifun_d;
            vala_q        <= vala_d;
            valb_q        <= valb_d;
            valc_q        <= valc_d;
            dste_q        <= dste_d;
            dstm_q        <= dstm_d;
            stat_q        <= stat_d;
            cc_q          <= cc_d;
            cnt_exec_q    <= cnt_exec_d;
            cnt_mispred_q <= cnt_mispred_d;
        end
    end

    assign E_icode     = icode_q;
    assign E_ifun      = ifun_q;
    assign E_valA      = vala_q;
    assign E_valB      = valb_q;
    assign E_valC      = valc_q;
    assign E_dstM      = dstm_q;
    assign E_stat      = stat_q;
    assign cc          = cc_q;
    assign cnt_exec    = cnt_exec_q;
    assign cnt_mispred = cnt_mispred_q;
    assign set_cc      = set_cc_w;
    assign e_cnd       = ((icode_q == I_RRMOV) || (icode_q == I_JXX)) ? cond : 1'b0;
    // A cmov whose condition fails writes no register.
    assign e_dstE      = ((icode_q == I_RRMOV) && !cond) ? RNONE : dste_q;

endmodule
